demux14_2bit: RTL and testbench

1-to-4 demultiplexer for 2-bit data, the write-side counterpart of the 4-to-1 2-bit selector. A strobed 2-bit symbol D is steered into one of four registered output lanes Q0..Q3. The lane comes from an external select (addressed mode) or from an internal wrap-around pointer (sequential mode). The block tracks which lanes have been written in the current frame and pulses frame_done when all four are filled. It drives one 7-segment digit with the most recently written lane index.

---
 rtl/demux14_2bit.sv | 83 ++++++++
 tb/tb_demux14_2bit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux14_2bit.sv
// demux14_2bit: 1-to-4 demux for 2-bit symbols with frame tracking.
// Lane comes from Y (addressed) or an internal wrap pointer (sequential).
module demux14_2bit #(
    parameter int W     = 2,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             clr,
    input  logic [W-1:0]     D,
    input  logic [1:0]       Y,
    output logic [W-1:0]     Q0,
    output logic [W-1:0]     Q1,
    output logic [W-1:0]     Q2,
    output logic [W-1:0]     Q3,
    output logic [1:0]       ptr,
    output logic [LANES-1:0] mask,
    output logic             frame_done,
    output logic             busy,
    output logic [7:0]       seg0
);

    logic [1:0]       lane;
    logic [LANES-1:0] oh;
    logic [LANES-1:0] nm;
    logic [7:0]       digit;

    always_comb begin
        lane     = mode ? ptr : Y;
        oh       = '0;
        oh[lane] = 1'b1;
        nm       = mask | oh;
        digit    = 8'hFF;
        unique case (lane)
            2'd0: digit = 8'hC0;
            2'd1: digit = 8'hF9;
            2'd2: digit = 8'hA4;
            2'd3: digit = 8'hB0;
        endcase
    end

    assign busy = |mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Q0         <= '0;
            Q1         <= '0;
            Q2         <= '0;
            Q3         <= '0;
            ptr        <= '0;
            mask       <= '0;
            frame_done <= 1'b0;
            seg0       <= 8'hFF;
        end else if (clr) begin
            mask       <= '0;
            ptr        <= '0;
            frame_done <= 1'b0;
        end else if (en) begin
            unique case (lane)
                2'd0: Q0 <= D;
                2'd1: Q1 <= D;
                2'd2: Q2 <= D;
                2'd3: Q3 <= D;
            endcase
            seg0 <= digit;
            if (mode)
                ptr <= ptr + 2'd1;
            // a full mask closes the frame and starts the next one empty
            if (&nm) begin
                mask       <= '0;
                frame_done <= 1'b1;
            end else begin
                mask       <= nm;
                frame_done <= 1'b0;
            end
        end else begin
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux14_2bit.sv
// tb_demux14_2bit: scoreboard bench for demux14_2bit.
// Expected state is queued at drive time and compared after the edge.
module tb_demux14_2bit;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic       clr;
    logic [1:0] D;
    logic [1:0] Y;
    logic [1:0] Q0, Q1, Q2, Q3;
    logic [1:0] ptr;
    logic [3:0] mask;
    logic       frame_done;
    logic       busy;
    logic [7:0] seg0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] q0;
        logic [1:0] q1;
        logic [1:0] q2;
        logic [1:0] q3;
        logic [1:0] ptr;
        logic [3:0] mask;
        logic       fd;
        logic       busy;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];

    logic [1:0] m_q [4];
    logic [1:0] m_ptr;
    logic [3:0] m_mask;
    logic       m_fd;
    logic [7:0] m_seg;
    logic [7:0] segtab [4];

    demux14_2bit #(.W(2), .LANES(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr),
        .D(D), .Y(Y), .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
        .ptr(ptr), .mask(mask), .frame_done(frame_done),
        .busy(busy), .seg0(seg0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_q[i] = 2'd0;
        m_ptr  = 2'd0;
        m_mask = 4'd0;
        m_fd   = 1'b0;
        m_seg  = 8'hFF;
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.q0   = m_q[0];
        e.q1   = m_q[1];
        e.q2   = m_q[2];
        e.q3   = m_q[3];
        e.ptr  = m_ptr;
        e.mask = m_mask;
        e.fd   = m_fd;
        e.busy = (m_mask != 4'd0);
        e.seg  = m_seg;
        return e;
    endfunction

    task automatic cmp_state(string tag, exp_t e);
        chk({tag, ".q0"}, 32'(Q0), 32'(e.q0));
        chk({tag, ".q1"}, 32'(Q1), 32'(e.q1));
        chk({tag, ".q2"}, 32'(Q2), 32'(e.q2));
        chk({tag, ".q3"}, 32'(Q3), 32'(e.q3));
        chk({tag, ".ptr"}, 32'(ptr), 32'(e.ptr));
        chk({tag, ".mask"}, 32'(mask), 32'(e.mask));
        chk({tag, ".fd"}, 32'(frame_done), 32'(e.fd));
        chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
        chk({tag, ".seg"}, 32'(seg0), 32'(e.seg));
    endtask

    // drive one cycle from negedge, update model, compare at next negedge
    task automatic step(string tag, logic s_en, logic s_mode, logic s_clr,
                        logic [1:0] s_d, logic [1:0] s_y);
        logic [1:0] l;
        logic [3:0] nm;
        exp_t e;
        en   = s_en;
        mode = s_mode;
        clr  = s_clr;
        D    = s_d;
        Y    = s_y;
        if (s_clr) begin
            m_mask = 4'd0;
            m_ptr  = 2'd0;
            m_fd   = 1'b0;
        end else if (s_en) begin
            l      = s_mode ? m_ptr : s_y;
            m_q[l] = s_d;
            m_seg  = segtab[l];
            if (s_mode) m_ptr = m_ptr + 2'd1;
            nm = m_mask | (4'd1 << l);
            if (nm == 4'hF) begin
                m_mask = 4'd0;
                m_fd   = 1'b1;
            end else begin
                m_mask = nm;
                m_fd   = 1'b0;
            end
        end else begin
            m_fd = 1'b0;
        end
        sb.push_back(snap());
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".sb"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp_state(tag, e);
        end
    endtask

    initial begin
        segtab[0] = 8'hC0;
        segtab[1] = 8'hF9;
        segtab[2] = 8'hA4;
        segtab[3] = 8'hB0;
        model_reset();
        rst  = 1'b0;
        en   = 1'b0;
        mode = 1'b0;
        clr  = 1'b0;
        D    = 2'd0;
        Y    = 2'd0;
        repeat (2) @(negedge clk);
        cmp_state("rst", snap());
        rst = 1'b1;

        for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0, 2'd3, 2'd1);

        // sequential frame D=3,1,2,0
        step("seq0", 1'b1, 1'b1, 1'b0, 2'd3, 2'd0);
        step("seq1", 1'b1, 1'b1, 1'b0, 2'd1, 2'd3);
        step("seq2", 1'b1, 1'b1, 1'b0, 2'd2, 2'd3);
        step("seq3", 1'b1, 1'b1, 1'b0, 2'd0, 2'd3);
        chk("seq_fd", 32'(frame_done), 32'd1);
        chk("seq_seg", 32'(seg0), 32'hB0);
        chk("seq_q0", 32'(Q0), 32'd3);
        step("seq_idle", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
        chk("seq_fd_off", 32'(frame_done), 32'd0);

        // addressed, out of order, duplicate lane 2
        step("adr0", 1'b1, 1'b0, 1'b0, 2'd1, 2'd2);
        step("adr1", 1'b1, 1'b0, 1'b0, 2'd3, 2'd2);
        chk("adr_dup_mask", 32'(mask), 32'h4);
        chk("adr_dup_fd", 32'(frame_done), 32'd0);
        step("adr2", 1'b1, 1'b0, 1'b0, 2'd2, 2'd0);
        step("adr3", 1'b1, 1'b0, 1'b0, 2'd1, 2'd3);
        step("adr4", 1'b1, 1'b0, 1'b0, 2'd0, 2'd1);
        chk("adr_fd", 32'(frame_done), 32'd1);
        chk("adr_q2", 32'(Q2), 32'd3);
        chk("adr_ptr", 32'(ptr), 32'd0);

        // clr beats en
        step("clr_a", 1'b1, 1'b0, 1'b0, 2'd1, 2'd0);
        step("clr_b", 1'b1, 1'b0, 1'b0, 2'd2, 2'd1);
        chk("clr_pre_mask", 32'(mask), 32'h3);
        step("clr", 1'b1, 1'b0, 1'b1, 2'd2, 2'd3);
        chk("clr_q3", 32'(Q3), 32'd1);
        chk("clr_mask", 32'(mask), 32'd0);

        // mode switch mid-frame
        step("ms0", 1'b1, 1'b1, 1'b0, 2'd1, 2'd0);
        step("ms1", 1'b1, 1'b1, 1'b0, 2'd2, 2'd0);
        step("ms2", 1'b1, 1'b0, 1'b0, 2'd3, 2'd3);
        step("ms3", 1'b1, 1'b0, 1'b0, 2'd0, 2'd2);
        chk("ms_fd", 32'(frame_done), 32'd1);
        chk("ms_ptr", 32'(ptr), 32'd2);
        step("ms4", 1'b1, 1'b1, 1'b0, 2'd1, 2'd0);
        chk("ms_lane2", 32'(Q2), 32'd1);
        chk("ms_seg", 32'(seg0), 32'hA4);

        // random mix
        for (int i = 0; i < 60; i++)
            step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom_range(0, 9) == 0), 2'($urandom), 2'($urandom));

        // async reset with mask=0111
        step("ar_c", 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
        step("ar0", 1'b1, 1'b1, 1'b0, 2'd1, 2'd0);
        step("ar1", 1'b1, 1'b1, 1'b0, 2'd2, 2'd0);
        step("ar2", 1'b1, 1'b1, 1'b0, 2'd3, 2'd0);
        chk("ar_pre_mask", 32'(mask), 32'h7);
        en = 1'b1;
        #2 rst = 1'b0;
        #1;
        model_reset();
        cmp_state("ar_now", snap());
        @(posedge clk);
        #1 chk("ar_fd_hold", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step("ar_idle", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step("ar_post", 1'b1, 1'b1, 1'b0, 2'd2, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
